// File: rtl/ll_fifo_scheduler.sv
// Front-end scheduler for the shared linked-list multi-FIFO.
// Round-robin arbitrates producer pushes, round-robin schedules pops into a
// registered output stage, and caps each queue's occupancy so no queue can
// hog the shared storage. Assumes NUM_FIFOS >= 2.

// Per-queue occupancy counter; saturates at both ends so it can never wrap.
module ll_fifo_occ #(
  parameter int CNT_WIDTH    = 3,
  parameter int MAX_PER_FIFO = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 dec,
  output logic [CNT_WIDTH-1:0] occ,
  output logic                 below_cap
);

  assign below_cap = (occ < CNT_WIDTH'(MAX_PER_FIFO));

  // Count pushes minus pops; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk) begin
    if (rst)
      occ <= '0;
    else if (inc && !dec && below_cap)
      occ <= occ + 1'b1;
    else if (dec && !inc && occ != '0)
      occ <= occ - 1'b1;
  end

endmodule

module ll_fifo_scheduler #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 4,
  parameter int NUM_FIFOS    = 2,
  parameter int MAX_PER_FIFO = DEPTH,
  parameter int SEL_WIDTH    = $clog2(NUM_FIFOS),
  parameter int CNT_WIDTH    = $clog2(DEPTH+1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_FIFOS-1:0]       in_valid,
  input  logic [NUM_FIFOS*WIDTH-1:0] in_data,
  output logic [NUM_FIFOS-1:0]       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [SEL_WIDTH-1:0]       out_sel,
  input  logic                       out_ready,
  output logic                       push,
  output logic [SEL_WIDTH-1:0]       push_sel,
  output logic [WIDTH-1:0]           data_in,
  output logic                       pop,
  output logic [SEL_WIDTH-1:0]       pop_sel,
  input  logic                       full,
  input  logic [NUM_FIFOS-1:0]       empty,
  input  logic [WIDTH-1:0]           data_out
);

  logic [SEL_WIDTH-1:0]                push_ptr, pop_ptr;
  logic [NUM_FIFOS-1:0][CNT_WIDTH-1:0] occ;
  logic [NUM_FIFOS-1:0][WIDTH-1:0]     in_data_a;
  logic [NUM_FIFOS-1:0]                below_cap, push_elig, pop_elig;
  logic [NUM_FIFOS-1:0]                push_oh, pop_oh;
  logic                                push_found, pop_found, slot_avail;
  logic [SEL_WIDTH-1:0]                push_g, pop_g;

  // Queue index base+off, wrapped modulo NUM_FIFOS.
  function automatic logic [SEL_WIDTH-1:0] wrap_add(input logic [SEL_WIDTH-1:0] base,
                                                    input int off);
    return SEL_WIDTH'((int'(base) + off) % NUM_FIFOS);
  endfunction

  assign in_data_a  = in_data;
  assign slot_avail = ~out_valid | out_ready;
  // Nothing is issued while rst is high, so the shared FIFO sees a clean reset.
  assign push_elig  = in_valid & below_cap & {NUM_FIFOS{~full & ~rst}};
  assign pop_elig   = ~empty & {NUM_FIFOS{slot_avail & ~rst}};

  // Push arbiter: first eligible producer scanning from push_ptr.
  always_comb begin
    push_found = 1'b0;
    push_g     = '0;
    for (int k = 0; k < NUM_FIFOS; k++) begin
      if (!push_found && push_elig[wrap_add(push_ptr, k)]) begin
        push_found = 1'b1;
        push_g     = wrap_add(push_ptr, k);
      end
    end
  end

  // Pop scheduler: first non-empty queue scanning from pop_ptr.
  always_comb begin
    pop_found = 1'b0;
    pop_g     = '0;
    for (int k = 0; k < NUM_FIFOS; k++) begin
      if (!pop_found && pop_elig[wrap_add(pop_ptr, k)]) begin
        pop_found = 1'b1;
        pop_g     = wrap_add(pop_ptr, k);
      end
    end
  end

  // One-hot views of the grants drive in_ready and the occupancy lanes.
  always_comb begin
    push_oh = '0;
    pop_oh  = '0;
    for (int i = 0; i < NUM_FIFOS; i++) begin
      push_oh[i] = push_found && (push_g == SEL_WIDTH'(i));
      pop_oh[i]  = pop_found  && (pop_g  == SEL_WIDTH'(i));
    end
  end

  assign in_ready = push_oh;
  assign push     = push_found;
  assign push_sel = push_g;
  assign data_in  = push_found ? in_data_a[push_g] : '0;
  assign pop      = pop_found;
  assign pop_sel  = pop_g;

  // Round-robin pointers advance past the queue just served.
  always_ff @(posedge clk) begin
    if (rst) begin
      push_ptr <= '0;
      pop_ptr  <= '0;
    end else begin
      if (push_found) push_ptr <= wrap_add(push_g, 1);
      if (pop_found)  pop_ptr  <= wrap_add(pop_g, 1);
    end
  end

  // Output stage: capture the fall-through head on a pop, drop after consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (pop_found) begin
      out_valid <= 1'b1;
      out_data  <= data_out;
      out_sel   <= pop_g;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_lane
    ll_fifo_occ #(
      .CNT_WIDTH    (CNT_WIDTH),
      .MAX_PER_FIFO (MAX_PER_FIFO)
    ) u_occ (
      .clk       (clk),
      .rst       (rst),
      .inc       (push_oh[i]),
      .dec       (pop_oh[i]),
      .occ       (occ[i]),
      .below_cap (below_cap[i])
    );
  end

endmodule

// File: tb/tb_ll_fifo_scheduler.sv
// Directed bench for ll_fifo_scheduler with a behavioural shared-FIFO model
// and an output scoreboard drained by an independent monitor.
module tb_ll_fifo_scheduler;

  localparam int W = 8, D = 4, N = 2, MAXQ = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_ready;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_data;
  logic          out_sel;
  logic          push, pop, full;
  logic          push_sel, pop_sel;
  logic [W-1:0]  data_in, data_out;
  logic [N-1:0]  empty;
  logic          hide;   // mask queues as empty to let storage fill up

  typedef struct packed { logic sel; logic [W-1:0] data; } exp_t;
  exp_t exp_q[$];
  exp_t e;

  int errors = 0;
  int checks = 0;

  // Shared FIFO model state.
  int         m_cnt [N];
  logic [W-1:0] m_mem [N][D];

  ll_fifo_scheduler #(
    .WIDTH(W), .DEPTH(D), .NUM_FIFOS(N), .MAX_PER_FIFO(MAXQ)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready),
    .push(push), .push_sel(push_sel), .data_in(data_in),
    .pop(pop), .pop_sel(pop_sel),
    .full(full), .empty(empty), .data_out(data_out)
  );

  always #5 clk = ~clk;

  assign full     = (m_cnt[0] + m_cnt[1]) == D;
  assign empty[0] = hide | (m_cnt[0] == 0);
  assign empty[1] = hide | (m_cnt[1] == 0);
  assign data_out = m_mem[pop_sel][0];

  // Shared FIFO model: per-queue shift register, head at index 0.
  always @(posedge clk) begin
    if (rst) begin
      for (int q = 0; q < N; q++) m_cnt[q] <= 0;
    end else begin
      for (int q = 0; q < N; q++) begin
        if (pop && pop_sel == q[0])
          for (int k = 0; k < D-1; k++) m_mem[q][k] <= m_mem[q][k+1];
        if (push && push_sel == q[0])
          m_mem[q][m_cnt[q] - ((pop && pop_sel == q[0]) ? 1 : 0)] <= data_in;
        m_cnt[q] <= m_cnt[q] + ((push && push_sel == q[0]) ? 1 : 0)
                             - ((pop && pop_sel == q[0]) ? 1 : 0);
      end
    end
  end

  // Monitor: environment legality and the output scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (push) begin
        checks++;
        if (full) begin errors++; $display("FAIL push_while_full: push=1 full=1 required no push"); end
      end
      if (pop) begin
        checks++;
        if (empty[pop_sel]) begin errors++; $display("FAIL pop_while_empty: pop_sel=%0d empty", pop_sel); end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: sel=%0d data=%0h with nothing expected", out_sel, out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_sel !== e.sel || out_data !== e.data) begin
            errors++;
            $display("FAIL out_word: got sel=%0d data=%0h expected sel=%0d data=%0h",
                     out_sel, out_data, e.sel, e.data);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [W-1:0] d1, input logic [W-1:0] d0);
    in_valid = v;
    in_data  = {d1, d0};
  endtask

  initial begin
    rst = 1'b1; hide = 1'b1; out_ready = 1'b0;
    drive(2'b00, 8'h00, 8'h00);
    cyc(); cyc(); #3;
    // Reset state.
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_occ", dut.occ, 0);
    chk("rst_ptrs", {dut.push_ptr, dut.pop_ptr}, 0);
    cyc();
    rst = 1'b0;

    // Fill: alternating grants until storage is full.
    for (int c = 0; c < 4; c++) begin
      drive(2'b11, 8'(8'hB0 + c), 8'(8'hA0 + c));
      #3;
      chk("fill_in_ready", in_ready, (c % 2 == 0) ? 2'b01 : 2'b10);
      chk("fill_data_in", data_in, (c % 2 == 0) ? 8'(8'hA0 + c) : 8'(8'hB0 + c));
      cyc();
    end
    #3;
    chk("full_in_ready", in_ready, 2'b00);
    chk("full_push", push, 0);
    cyc();

    // Drain with out_ready=1: pops alternate q0,q1.
    exp_q.push_back('{1'b0, 8'hA0});
    exp_q.push_back('{1'b1, 8'hB1});
    exp_q.push_back('{1'b0, 8'hA2});
    exp_q.push_back('{1'b1, 8'hB3});
    drive(2'b00, 8'h00, 8'h00);
    hide = 1'b0; out_ready = 1'b1;
    #3;
    chk("alt_pop0", {pop, pop_sel}, 2'b10);
    chk("alt_outv0", out_valid, 0);
    cyc(); #3;
    chk("alt_pop1", {pop, pop_sel}, 2'b11);
    chk("alt_outv1", out_valid, 1);
    chk("alt_data1", out_data, 8'hA0);
    for (int c = 0; c < 4; c++) cyc();

    // Per-queue cap: only queue 0 pushes, storage never full.
    hide = 1'b1;
    drive(2'b01, 8'h00, 8'hC0);
    #3; chk("cap_rdy0", in_ready, 2'b01); cyc();
    drive(2'b01, 8'h00, 8'hC1);
    #3; chk("cap_rdy1", in_ready, 2'b01); cyc();
    drive(2'b01, 8'h00, 8'hC2);
    #3;
    chk("cap_rdy2", in_ready, 2'b00);
    chk("cap_not_full", full, 0);
    chk("cap_occ0", dut.occ[0], 2);
    cyc();
    exp_q.push_back('{1'b0, 8'hC0});
    exp_q.push_back('{1'b0, 8'hC1});
    exp_q.push_back('{1'b0, 8'hC2});
    hide = 1'b0;
    #3;
    chk("cap_pop_rdy", in_ready, 2'b00);
    chk("cap_pop", {pop, pop_sel}, 2'b10);
    cyc(); #3;
    chk("cap_reenable", in_ready, 2'b01);
    cyc();
    drive(2'b00, 8'h00, 8'h00);
    for (int c = 0; c < 3; c++) cyc();

    // Output stall: out_ready=0 holds the stage and blocks pops.
    hide = 1'b1; out_ready = 1'b0;
    drive(2'b11, 8'hE0, 8'hD0); cyc();
    drive(2'b11, 8'hE1, 8'hD1); cyc();
    exp_q.push_back('{1'b1, 8'hE0});
    exp_q.push_back('{1'b0, 8'hD1});
    drive(2'b00, 8'h00, 8'h00);
    hide = 1'b0;
    #3; chk("stall_first_pop", {pop, pop_sel}, 2'b11);
    cyc();
    for (int c = 0; c < 3; c++) begin
      #3;
      chk("stall_pop", pop, 0);
      chk("stall_data", {out_valid, out_sel, out_data}, {1'b1, 1'b1, 8'hE0});
      cyc();
    end
    out_ready = 1'b1;
    #3; chk("resume_pop", {pop, pop_sel}, 2'b10);
    for (int c = 0; c < 4; c++) cyc();

    // Push to empty queue 1: pop only on the following cycle.
    exp_q.push_back('{1'b1, 8'h5A});
    drive(2'b10, 8'h5A, 8'h00);
    #3;
    chk("same_push", {push, push_sel}, 2'b11);
    chk("same_no_pop", pop, 0);
    cyc();
    drive(2'b00, 8'h00, 8'h00);
    #3;
    chk("same_pop_t1", {pop, pop_sel}, 2'b11);
    chk("same_outv_t1", out_valid, 0);
    cyc(); #3;
    chk("same_out_t2", {out_valid, out_sel, out_data}, {1'b1, 1'b1, 8'h5A});
    cyc(); cyc();

    // Reset during simultaneous push and pop.
    hide = 1'b1;
    drive(2'b01, 8'h00, 8'hF0); cyc();
    hide = 1'b0;
    drive(2'b01, 8'h00, 8'hF1);
    #3; chk("rst_mid_pushpop", {push, pop}, 2'b11);
    cyc();
    rst = 1'b1;
    #3;
    chk("rst_mid_quiet", {push, pop, in_ready}, 4'b0000);
    cyc(); #3;
    chk("rst_mid_outv", out_valid, 0);
    chk("rst_mid_occ", dut.occ, 0);
    chk("rst_mid_ptrs", {dut.push_ptr, dut.pop_ptr}, 0);
    cyc();
    rst = 1'b0;
    drive(2'b00, 8'h00, 8'h00);
    for (int c = 0; c < 3; c++) cyc();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ll_fifo_scheduler.md
Name: ll_fifo_scheduler

Overview:
- Front-end controller for the shared linked-list multi-FIFO (NUM_FIFOS logical queues sharing DEPTH entries through a free list).
- Accepts NUM_FIFOS independent valid/ready producer streams and round-robin arbitrates one push per cycle into the shared FIFO.
- Round-robin schedules pops from non-empty queues into a single registered valid/ready output stage.
- Caps each queue's occupancy at MAX_PER_FIFO so one queue cannot starve the others of shared storage.

Parameters:
- WIDTH, 8, data width.
- DEPTH, 4, total shared FIFO entries.
- NUM_FIFOS, 2, number of logical queues and producers.
- MAX_PER_FIFO, DEPTH, per-queue occupancy cap, legal range 1..DEPTH.
- SEL_WIDTH, $clog2(NUM_FIFOS), queue select width.
- CNT_WIDTH, $clog2(DEPTH+1), occupancy counter width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  NUM_FIFOS  producer i has data
- in_data  input  NUM_FIFOS*WIDTH  producer i data in slice [i*WIDTH +: WIDTH]
- in_ready  output  NUM_FIFOS  producer i accepted this cycle; at most one bit set
- out_valid  output  1  output stage holds data
- out_data  output  WIDTH  popped data
- out_sel  output  SEL_WIDTH  queue the output data came from
- out_ready  input  1  consumer accepts out_data
- push  output  1  to shared FIFO
- push_sel  output  SEL_WIDTH  to shared FIFO
- data_in  output  WIDTH  to shared FIFO
- pop  output  1  to shared FIFO
- pop_sel  output  SEL_WIDTH  to shared FIFO
- full  input  1  shared FIFO has no free entry
- empty  input  NUM_FIFOS  per-queue empty from shared FIFO
- data_out  input  WIDTH  head of queue pop_sel, combinational (first-word fall-through)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state: out_valid=0, out_data=0, out_sel=0, push_ptr=0, pop_ptr=0, all occ[i]=0. Combinational outputs follow from this state.
- Push eligibility: queue i is eligible when in_valid[i], ~full and occ[i] < MAX_PER_FIFO.
- Push grant: the first eligible index scanning push_ptr, push_ptr+1, ... modulo NUM_FIFOS.
- On a grant g:
  - push=1, push_sel=g, data_in=in_data slice g, in_ready=one-hot(g).
  - push_ptr <= (g+1) mod NUM_FIFOS.
- No grant: push=0, in_ready=0, push_sel=0, data_in=0, push_ptr holds.
- Push-side readiness: in_ready depends combinationally on in_valid and on registered state. in_ready never asserts for an ineligible queue.
- Pop slot availability: the output stage can take data when ~out_valid or out_ready.
- Pop grant: when a slot is available, pick the first queue j with ~empty[j], scanning from pop_ptr modulo NUM_FIFOS.
- On a pop grant j:
  - pop=1, pop_sel=j.
  - Next cycle: out_valid=1, out_data=data_out as sampled this cycle, out_sel=j.
  - pop_ptr <= (j+1) mod NUM_FIFOS.
- Pop latency: 1 cycle from pop to out_valid. Sustained throughput is one word per cycle while out_ready=1.
- No pop grant: pop=0, pop_sel=0. out_valid clears if out_ready was 1 and holds otherwise. out_data and out_sel hold until replaced.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_sel stay stable and pop=0.
- Occupancy counter per queue:
  - +1 on push to i, -1 on pop from i, unchanged when both happen in the same cycle.
  - Never wraps. With correct operation it stays within 0..MAX_PER_FIFO.
- Push and pop to the same empty queue in one cycle: the pop is not issued, because empty is still 1. The word becomes poppable next cycle.
- A push while full=1 is never issued; a pop of an empty queue is never issued. These satisfy the shared FIFO's environmental assumptions.
- Reset mid-operation: all state returns to reset values on the next edge regardless of in-flight handshakes. The shared FIFO is reset by the same rst.
- Formal hook: under any legal input, the properties "~(push & full)", "~(pop & empty[pop_sel])" and "occ[i] <= MAX_PER_FIFO" hold every cycle.

Test Plan:
- NUM_FIFOS=2, DEPTH=4. After rst, in_valid=2'b11 held for 4 cycles -> in_ready alternates 01,10,01,10. Then full=1 and in_ready=00.
- MAX_PER_FIFO=2, only in_valid[0]=1 -> exactly 2 pushes to queue 0, then in_ready[0]=0 while full=0. One pop of queue 0 re-enables one push.
- Queues 0 and 1 each hold data (0xA1 in queue 0, 0xB1 in queue 1), out_ready=1 -> pops alternate: out_sel 0,1,... with out_data 0xA1 then 0xB1. out_valid goes high 1 cycle after the first pop.
- out_ready=0 with out_valid=1 for 3 cycles -> pop=0 and out_data stable. Raise out_ready -> back-to-back pops resume the following cycle.
- Empty queue 1, push to queue 1 in cycle t -> no pop in cycle t. pop=1 with pop_sel=1 in cycle t+1, and out_valid in cycle t+2.
- Assert rst during simultaneous push and pop -> next cycle out_valid=0, occ=0, both pointers=0, and no push or pop issued while rst=1.
